// File: rtl/btn_debounce_irq.sv
// Button conditioner: 2-FF sync, per-bit debounce, press/release pulses, pending mask and level IRQ.
// Optional autorepeat of press pulses while held: define BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_irq #(
    parameter int unsigned                C_btn_bits          = 7,
    parameter logic [C_btn_bits-1:0]      C_btn_active_low    = 7'b0000001,
    parameter int unsigned                C_debounce_bits     = 16,
    parameter int unsigned                C_repeat_delay_bits = 24,
    parameter int unsigned                C_repeat_rate_bits  = 22
) (
    input  logic                  clk_25mhz,
    input  logic                  reset,
    input  logic [C_btn_bits-1:0] btn_raw,
    input  logic                  ack,
    input  logic [C_btn_bits-1:0] ack_mask,
    output logic [C_btn_bits-1:0] btn_stable,
    output logic [C_btn_bits-1:0] btn_press,
    output logic [C_btn_bits-1:0] btn_release,
    output logic [C_btn_bits-1:0] pending,
    output logic                  irq
);

    localparam int unsigned NB = C_btn_bits;
    localparam int unsigned DW = C_debounce_bits;
    localparam logic [DW-1:0] CNT_MAX = '1;

    // The repeat counter reuses its low bits for the rate period, so rate must not exceed delay.
    if (C_repeat_rate_bits > C_repeat_delay_bits || C_repeat_rate_bits == 0) begin : g_bad_repeat_cfg
        $error("btn_debounce_irq: C_repeat_rate_bits must be in 1..C_repeat_delay_bits");
    end

    logic [NB-1:0] sync_a;
    logic [NB-1:0] sync_b;
    logic [NB-1:0] s_lvl;
    logic [DW-1:0] cnt     [NB];
    logic [DW-1:0] cnt_nxt [NB];
    logic [NB-1:0] stable_nxt;
    logic [NB-1:0] rise;
    logic [NB-1:0] fall;
    logic [NB-1:0] press_nxt;
    logic [NB-1:0] ack_clr;

    // Two-stage synchroniser; polarity normalised so 1 = pressed.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    assign s_lvl = sync_b ^ C_btn_active_low;

    // Debounce window: level must differ from stable for 2^DW consecutive samples.
    always_comb begin
        stable_nxt = btn_stable;
        rise       = '0;
        fall       = '0;
        for (int i = 0; i < int'(NB); i++) begin
            cnt_nxt[i] = cnt[i];
            if (s_lvl[i] == btn_stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                cnt_nxt[i]    = '0;
                stable_nxt[i] = s_lvl[i];
                rise[i]       = s_lvl[i];
                fall[i]       = ~s_lvl[i];
            end else begin
                cnt_nxt[i] = cnt[i] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            for (int i = 0; i < int'(NB); i++) begin
                cnt[i] <= '0;
            end
            btn_stable  <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < int'(NB); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            btn_stable  <= stable_nxt;
            btn_press   <= press_nxt;
            btn_release <= fall;
        end
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned RW = C_repeat_delay_bits;
    localparam logic [RW-1:0] DELAY_MAX = '1;
    localparam logic [RW-1:0] RATE_MAX  = RW'({C_repeat_rate_bits{1'b1}});

    logic [RW-1:0] rep_cnt [NB];
    logic [NB-1:0] rep_fast;
    logic [NB-1:0] rep_hit;

    // First repeat after the long delay, then at the shorter rate; a releasing bit never repeats.
    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < int'(NB); i++) begin
            rep_hit[i] = btn_stable[i] & stable_nxt[i] &
                         (rep_fast[i] ? (rep_cnt[i] == RATE_MAX) : (rep_cnt[i] == DELAY_MAX));
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            for (int i = 0; i < int'(NB); i++) begin
                rep_cnt[i] <= '0;
            end
            rep_fast <= '0;
        end else begin
            for (int i = 0; i < int'(NB); i++) begin
                if (!btn_stable[i]) begin
                    rep_cnt[i]  <= '0;
                    rep_fast[i] <= 1'b0;
                end else if (rep_hit[i]) begin
                    rep_cnt[i]  <= '0;
                    rep_fast[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + RW'(1);
                end
            end
        end
    end

    assign press_nxt = rise | rep_hit;
`else
    assign press_nxt = rise;
`endif

    assign ack_clr = ack_mask & {NB{ack}};

    // A press in the same cycle as its ack is kept so no event is lost.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~ack_clr) | btn_press;
            irq     <= |pending;
        end
    end

endmodule

// File: tb/tb_btn_debounce_irq.sv
// Directed bench for btn_debounce_irq with a 16-cycle debounce window.
module tb_btn_debounce_irq;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] btn_raw;
    logic       ack;
    logic [6:0] ack_mask;
    logic [6:0] btn_stable;
    logic [6:0] btn_press;
    logic [6:0] btn_release;
    logic [6:0] pending;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    btn_debounce_irq #(
        .C_btn_bits          (7),
        .C_btn_active_low    (7'b0000001),
        .C_debounce_bits     (4),
        .C_repeat_delay_bits (6),
        .C_repeat_rate_bits  (4)
    ) dut (
        .clk_25mhz   (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .ack         (ack),
        .ack_mask    (ack_mask),
        .btn_stable  (btn_stable),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .pending     (pending),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt_p;
        logic exp_p;

        // Reset with all pins high
        reset = 1'b1; btn_raw = 7'h7F; ack = 1'b0; ack_mask = 7'h00;
        tick(3);
        chk("rst_stable",  8'(btn_stable),  8'h00);
        chk("rst_press",   8'(btn_press),   8'h00);
        chk("rst_release", 8'(btn_release), 8'h00);
        chk("rst_pending", 8'(pending),     8'h00);
        chk("rst_irq",     8'(irq),         8'h00);
        reset = 1'b0;
        tick(17);
        chk("t1_stable_early", 8'(btn_stable), 8'h00);
        chk("t1_press_early",  8'(btn_press),  8'h00);
        tick(1);
        chk("t1_stable", 8'(btn_stable), 8'h7E);
        chk("t1_press",  8'(btn_press),  8'h7E);
        tick(1);
        chk("t1_press_end", 8'(btn_press), 8'h00);
        chk("t1_pending",   8'(pending),   8'h7E);
        tick(1);
        chk("t1_irq", 8'(irq), 8'h01);
        ack = 1'b1; ack_mask = 7'h7F;
        tick(1);
        ack = 1'b0; ack_mask = 7'h00;
        chk("t1_ack_pending", 8'(pending), 8'h00);
        chk("t1_ack_irq_lag", 8'(irq),     8'h01);
        tick(1);
        chk("t1_ack_irq", 8'(irq), 8'h00);
        btn_raw = 7'h01;
        tick(18);
        chk("t1_rel_stable", 8'(btn_stable),  8'h00);
        chk("t1_release",    8'(btn_release), 8'h7E);
        tick(1);
        chk("t1_release_end", 8'(btn_release), 8'h00);
        chk("t1_rel_pending", 8'(pending),     8'h00);

        // Single press on bit 3
        btn_raw = 7'h09;
        tick(17);
        chk("t2_stable_early", 8'(btn_stable), 8'h00);
        tick(1);
        chk("t2_stable", 8'(btn_stable), 8'h08);
        chk("t2_press",  8'(btn_press),  8'h08);
        tick(1);
        chk("t2_pending", 8'(pending),   8'h08);
        chk("t2_irq_lag", 8'(irq),       8'h00);
        chk("t2_press1",  8'(btn_press), 8'h00);
        tick(1);
        chk("t2_irq", 8'(irq), 8'h01);
        ack = 1'b1; ack_mask = 7'h08;
        tick(1);
        ack = 1'b0; ack_mask = 7'h00;
        chk("t2_ack_pending", 8'(pending), 8'h00);
        tick(2);
        chk("t2_ack_irq", 8'(irq), 8'h00);

        // Bouncing bit 3 must not change the stable level
        btn_raw = 7'h01;
        tick(18);
        chk("t3_rel_stable", 8'(btn_stable),  8'h00);
        chk("t3_release",    8'(btn_release), 8'h08);
        for (int k = 0; k < 6; k++) begin
            btn_raw = (k % 2 == 0) ? 7'h09 : 7'h01;
            for (int c = 0; c < 5; c++) begin
                tick(1);
                chk("t3_bounce_stable", 8'(btn_stable), 8'h00);
                chk("t3_bounce_press",  8'(btn_press),  8'h00);
            end
        end
        btn_raw = 7'h09;
        tick(17);
        chk("t3_stable_early", 8'(btn_stable), 8'h00);
        tick(1);
        chk("t3_stable", 8'(btn_stable), 8'h08);
        chk("t3_press",  8'(btn_press),  8'h08);

        // Pending mask with partial ack and press/ack collision
        btn_raw = 7'h0D;
        tick(18);
        chk("t4_stable", 8'(btn_stable), 8'h0C);
        chk("t4_press",  8'(btn_press),  8'h04);
        tick(1);
        chk("t4_pending", 8'(pending), 8'h0C);
        tick(1);
        chk("t4_irq", 8'(irq), 8'h01);
        ack = 1'b1; ack_mask = 7'h04;
        tick(1);
        ack = 1'b0; ack_mask = 7'h00;
        chk("t4_ack_pending", 8'(pending), 8'h08);
        tick(1);
        chk("t4_ack_irq", 8'(irq), 8'h01);
        ack = 1'b1; ack_mask = 7'h00;
        tick(1);
        ack = 1'b0;
        chk("t4_nop_ack", 8'(pending), 8'h08);
        btn_raw = 7'h09;
        tick(18);
        chk("t4_rel_stable", 8'(btn_stable),  8'h08);
        chk("t4_release",    8'(btn_release), 8'h04);
        btn_raw = 7'h0D;
        tick(18);
        chk("t4_repress", 8'(btn_press), 8'h04);
        ack = 1'b1; ack_mask = 7'h04;
        tick(1);
        ack = 1'b0; ack_mask = 7'h00;
        chk("t4_set_wins", 8'(pending),   8'h0C);
        chk("t4_press_end", 8'(btn_press), 8'h00);

        // Reset in the middle of a debounce window on bit 5
        btn_raw = 7'h01;
        tick(18);
        chk("t5_rel_stable", 8'(btn_stable),  8'h00);
        chk("t5_release",    8'(btn_release), 8'h0C);
        btn_raw = 7'h21;
        tick(9);
        chk("t5_pre_rst_stable", 8'(btn_stable), 8'h00);
        reset = 1'b1;
        tick(1);
        chk("t5_rst_stable",  8'(btn_stable), 8'h00);
        chk("t5_rst_press",   8'(btn_press),  8'h00);
        chk("t5_rst_pending", 8'(pending),    8'h00);
        chk("t5_rst_irq",     8'(irq),        8'h00);
        reset = 1'b0;
        tick(17);
        chk("t5_stable_early", 8'(btn_stable), 8'h00);
        chk("t5_press_early",  8'(btn_press),  8'h00);
        tick(1);
        chk("t5_stable", 8'(btn_stable), 8'h20);
        chk("t5_press",  8'(btn_press),  8'h20);

        // Hold bit 1: autorepeat only when built with the macro
        btn_raw = 7'h23;
        tick(18);
        chk("t6_stable", 8'(btn_stable), 8'h22);
        chk("t6_press",  8'(btn_press),  8'h02);
        for (int c = 1; c <= 120; c++) begin
            tick(1);
            exp_p = REP_ON && (c >= 64) && ((c - 64) % 16 == 0);
            chk("t6_hold_press1", 8'(btn_press[1]), 8'(exp_p));
        end
        btn_raw = 7'h21;
        tick(18);
        chk("t6_release", 8'(btn_release), 8'h02);
        cnt_p = 0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (btn_press[1]) cnt_p++;
        end
        chk("t6_no_press_after_release", 8'(cnt_p), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
